// File: rtl/adc_acq_pkg.sv
// Shared types, widths and helpers for the ADC acquisition scheduler.
// The sign-extension helper is tied to the package DATA_W/ACC_W widths.
package adc_acq_pkg;

    localparam int DATA_W  = 20;
    localparam int CNT_W   = 16;
    localparam int DECIM_W = 8;
    localparam int ACC_W   = 36;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACQ    = 2'd2,
        ST_HOLD   = 2'd3
    } acq_state_e;

    function automatic logic [ACC_W-1:0] sign_ext(input logic [DATA_W-1:0] x);
        return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

endpackage

// File: rtl/adc_acq_accum.sv
// Decimating sign-extending accumulator with sample counter and sticky overload flag.
// clr restarts a burst; en marks an ADC strobe that arrives while acquiring.
module adc_acq_accum
    import adc_acq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DECIM_W-1:0] decim,
    input  logic [DATA_W-1:0]  sample,
    input  logic               overload,
    output logic [ACC_W-1:0]   acc,
    output logic [CNT_W-1:0]   cnt,
    output logic               ovl_seen,
    output logic               take
);

    logic [DECIM_W-1:0] decim_cnt_r;

    // Strobe is accepted when the decimation countdown has expired
    assign take = (decim_cnt_r == {DECIM_W{1'b0}});

    // Accumulator, sample counter, decimation countdown and overload flag
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc         <= {ACC_W{1'b0}};
            cnt         <= {CNT_W{1'b0}};
            ovl_seen    <= 1'b0;
            decim_cnt_r <= {DECIM_W{1'b0}};
        end else if (en) begin
            if (take) begin
                acc         <= acc + sign_ext(sample);
                cnt         <= cnt + CNT_W'(1);
                ovl_seen    <= ovl_seen | overload;
                decim_cnt_r <= decim;
            end else begin
                decim_cnt_r <= decim_cnt_r - DECIM_W'(1);
            end
        end else begin
            decim_cnt_r <= decim_cnt_r;
        end
    end

endmodule

// File: rtl/adc_acq_sched.sv
// Burst scheduler for the serial-ADC front end: settle, decimate, accumulate N
// samples, then hand the signed sum to the consumer over valid/ready.
module adc_acq_sched
    import adc_acq_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [CNT_W-1:0]   i_num_samples,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic               i_sample_syn,
    input  logic [DATA_W-1:0]  i_sample,
    input  logic               i_overload,
    output logic               o_adc_en,
    output logic               o_busy,
    output logic [ACC_W-1:0]   o_acc,
    output logic [CNT_W-1:0]   o_acc_cnt,
    output logic               o_ovl_seen,
    output logic               o_acc_valid,
    input  logic               i_acc_ready,
    output logic               o_done
);

    localparam int SETTLE_W = 8;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    acq_state_e          state_r, state_d;
    logic [CNT_W-1:0]    n_r, n_d;
    logic [DECIM_W-1:0]  d_r, d_d;
    logic [SETTLE_W-1:0] settle_r, settle_d;
    logic                adc_en_r, adc_en_d;
    logic                valid_r, valid_d;
    logic                done_r, done_d;
    logic                acc_clr_s, acc_en_s, take_s, last_s;

    assign acc_en_s = (state_r == ST_ACQ) && i_sample_syn && !i_abort;
    assign last_s   = acc_en_s && take_s && ((o_acc_cnt + CNT_W'(1)) == n_r);

    adc_acq_accum u_accum (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (acc_clr_s),
        .en       (acc_en_s),
        .decim    (d_r),
        .sample   (i_sample),
        .overload (i_overload),
        .acc      (o_acc),
        .cnt      (o_acc_cnt),
        .ovl_seen (o_ovl_seen),
        .take     (take_s)
    );

    // State register and registered control outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            n_r      <= {CNT_W{1'b0}};
            d_r      <= {DECIM_W{1'b0}};
            settle_r <= {SETTLE_W{1'b0}};
            adc_en_r <= 1'b0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_d;
            n_r      <= n_d;
            d_r      <= d_d;
            settle_r <= settle_d;
            adc_en_r <= adc_en_d;
            valid_r  <= valid_d;
            done_r   <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_r;
        n_d       = n_r;
        d_d       = d_r;
        settle_d  = settle_r;
        adc_en_d  = adc_en_r;
        valid_d   = valid_r;
        done_d    = 1'b0;
        acc_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    acc_clr_s = 1'b1;
                    n_d       = (i_num_samples == {CNT_W{1'b0}}) ? CNT_W'(1) : i_num_samples;
                    d_d       = i_decim;
                    settle_d  = {SETTLE_W{1'b0}};
                    adc_en_d  = 1'b1;
                    state_d   = (SETTLE_SAMPLES == 0) ? ST_ACQ : ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    state_d  = ST_IDLE;
                    adc_en_d = 1'b0;
                    settle_d = {SETTLE_W{1'b0}};
                end else if (i_sample_syn) begin
                    if (settle_r == SETTLE_LAST) begin
                        state_d  = ST_ACQ;
                        settle_d = {SETTLE_W{1'b0}};
                    end else begin
                        settle_d = settle_r + SETTLE_W'(1);
                    end
                end else begin
                    settle_d = settle_r;
                end
            end
            ST_ACQ: begin
                if (i_abort) begin
                    state_d  = ST_IDLE;
                    adc_en_d = 1'b0;
                end else if (last_s) begin
                    state_d  = ST_HOLD;
                    adc_en_d = 1'b0;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d = ST_ACQ;
                end
            end
            ST_HOLD: begin
                if (i_abort || i_acc_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                adc_en_d = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    assign o_busy      = (state_r != ST_IDLE);
    assign o_adc_en    = adc_en_r;
    assign o_acc_valid = valid_r;
    assign o_done      = done_r;

endmodule

// File: tb/tb_adc_acq_sched.sv
// Self-checking bench for adc_acq_sched: directed scenarios plus randomized
// bursts checked against a settle/decimate/sum reference model.
module tb_adc_acq_sched;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0, i_start = 1'b0, i_abort = 1'b0;
    logic [15:0] i_num_samples = 16'd0;
    logic [7:0]  i_decim = 8'd0;
    logic        i_sample_syn = 1'b0, i_overload = 1'b0, i_acc_ready = 1'b0;
    logic [19:0] i_sample = 20'd0;
    logic        o_adc_en, o_busy, o_ovl_seen, o_acc_valid, o_done;
    logic [35:0] o_acc;
    logic [15:0] o_acc_cnt;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    adc_acq_sched dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_num_samples(i_num_samples), .i_decim(i_decim),
        .i_sample_syn(i_sample_syn), .i_sample(i_sample), .i_overload(i_overload),
        .o_adc_en(o_adc_en), .o_busy(o_busy), .o_acc(o_acc), .o_acc_cnt(o_acc_cnt),
        .o_ovl_seen(o_ovl_seen), .o_acc_valid(o_acc_valid), .i_acc_ready(i_acc_ready),
        .o_done(o_done)
    );

    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] n, input logic [7:0] d);
        i_num_samples = n;
        i_decim       = d;
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
        i_num_samples = 16'($urandom);
        i_decim       = 8'($urandom);
    endtask

    task automatic strobe(input logic [19:0] s, input logic ovl);
        i_sample_syn = 1'b1;
        i_sample     = s;
        i_overload   = ovl;
        tick();
        i_sample_syn = 1'b0;
        i_overload   = 1'b0;
    endtask

    task automatic release_result();
        i_acc_ready = 1'b1;
        tick();
        i_acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        total++;
        if ({o_adc_en, o_busy, o_ovl_seen, o_acc_valid, o_done} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {o_adc_en, o_busy, o_ovl_seen, o_acc_valid, o_done});
        end
        total++;
        if (o_acc !== 36'd0 || o_acc_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_acc: got acc=%h cnt=%0d want 0/0", o_acc, o_acc_cnt);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [19:0] v [4];
        int d0;
        v[0] = 20'h00001; v[1] = 20'h00002; v[2] = 20'hFFFFD; v[3] = 20'h00005;
        d0 = done_cnt;
        start_burst(16'd4, 8'd0);
        total++;
        if (o_busy !== 1'b1 || o_adc_en !== 1'b1) begin
            bad++;
            $display("FAIL basic_start: got busy=%b adc_en=%b want 1/1", o_busy, o_adc_en);
        end
        strobe(20'($urandom), 1'b1);
        strobe(20'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) strobe(v[i], 1'b0);
        total++;
        if (o_acc_valid !== 1'b1 || o_done !== 1'b1 || o_adc_en !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid: got valid=%b done=%b adc_en=%b want 1/1/0", o_acc_valid, o_done, o_adc_en);
        end
        total++;
        if (o_acc !== 36'd5 || o_acc_cnt !== 16'd4 || o_ovl_seen !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got acc=%0d cnt=%0d ovl=%b want 5/4/0", o_acc, o_acc_cnt, o_ovl_seen);
        end
        tick();
        total++;
        if (o_done !== 1'b0 || o_acc_valid !== 1'b1 || done_cnt !== d0 + 1) begin
            bad++;
            $display("FAIL basic_done_pulse: got done=%b valid=%b pulses=%0d want 0/1/1", o_done, o_acc_valid, done_cnt - d0);
        end
        release_result();
        total++;
        if (o_acc_valid !== 1'b0 || o_busy !== 1'b0 || o_acc !== 36'd5) begin
            bad++;
            $display("FAIL basic_release: got valid=%b busy=%b acc=%0d want 0/0/5", o_acc_valid, o_busy, o_acc);
        end
    endtask

    task automatic test_decim();
        int d0;
        d0 = done_cnt;
        start_burst(16'd3, 8'd2);
        strobe(20'h00000, 1'b0);
        strobe(20'h00000, 1'b0);
        for (int v = 1; v <= 11; v++) begin
            strobe(20'(v), 1'b0);
            if (v == 6) begin
                total++;
                if (o_adc_en !== 1'b1 || o_acc_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL decim_pre: got adc_en=%b valid=%b want 1/0", o_adc_en, o_acc_valid);
                end
            end else if (v == 7) begin
                total++;
                if (o_adc_en !== 1'b0 || o_acc_valid !== 1'b1 || o_acc !== 36'd12) begin
                    bad++;
                    $display("FAIL decim_valid: got adc_en=%b valid=%b acc=%0d want 0/1/12", o_adc_en, o_acc_valid, o_acc);
                end
            end
        end
        total++;
        if (o_acc !== 36'd12 || o_acc_cnt !== 16'd3 || done_cnt !== d0 + 1) begin
            bad++;
            $display("FAIL decim_hold: got acc=%0d cnt=%0d pulses=%0d want 12/3/1", o_acc, o_acc_cnt, done_cnt - d0);
        end
        release_result();
    endtask

    task automatic test_extremes();
        start_burst(16'd2, 8'd0);
        strobe(20'h00000, 1'b0);
        strobe(20'h00000, 1'b0);
        strobe(20'h80000, 1'b1);
        strobe(20'h7FFFF, 1'b0);
        total++;
        if (o_acc !== 36'hFFFFFFFFF || o_ovl_seen !== 1'b1 || o_acc_valid !== 1'b1) begin
            bad++;
            $display("FAIL extremes: got acc=%h ovl=%b valid=%b want fffffffff/1/1", o_acc, o_ovl_seen, o_acc_valid);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        logic [19:0]        s;
        logic signed [19:0] ss;
        longint             exp_sum;
        logic [35:0]        exp_acc;
        exp_sum = 0;
        start_burst(16'd3, 8'd1);
        strobe(20'($urandom), 1'b0);
        strobe(20'($urandom), 1'b0);
        for (int k = 0; k < 5; k++) begin
            s  = 20'($urandom);
            ss = s;
            if (k % 2 == 0) exp_sum += longint'(ss);
            strobe(s, 1'b0);
        end
        exp_acc = exp_sum[35:0];
        for (int c = 0; c < 10; c++) begin
            i_sample_syn = 1'b1;
            i_sample     = 20'($urandom);
            i_overload   = 1'b1;
            tick();
            total++;
            if (o_acc !== exp_acc || o_acc_cnt !== 16'd3 || o_acc_valid !== 1'b1 || o_ovl_seen !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold: cycle %0d got acc=%h cnt=%0d valid=%b ovl=%b want %h/3/1/0",
                         c, o_acc, o_acc_cnt, o_acc_valid, o_ovl_seen, exp_acc);
            end
        end
        i_sample_syn = 1'b0;
        i_overload   = 1'b0;
        release_result();
        total++;
        if (o_busy !== 1'b0 || o_acc_valid !== 1'b0 || o_acc !== exp_acc) begin
            bad++;
            $display("FAIL backpressure_release: got busy=%b valid=%b acc=%h want 0/0/%h", o_busy, o_acc_valid, o_acc, exp_acc);
        end
    endtask

    task automatic test_abort();
        int d0;
        start_burst(16'd8, 8'd0);
        strobe(20'h00000, 1'b0);
        strobe(20'h00000, 1'b0);
        strobe(20'h00003, 1'b0);
        strobe(20'h00004, 1'b0);
        d0 = done_cnt;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        total++;
        if ({o_busy, o_adc_en, o_acc_valid} !== 3'b000) begin
            bad++;
            $display("FAIL abort_idle: got busy/adc_en/valid=%b want 000", {o_busy, o_adc_en, o_acc_valid});
        end
        strobe(20'h00001, 1'b0);
        tick();
        total++;
        if (done_cnt !== d0 || o_acc_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got pulses=%0d valid=%b want 0/0", done_cnt - d0, o_acc_valid);
        end
        i_num_samples = 16'd1;
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_adc_en !== 1'b0) begin
            bad++;
            $display("FAIL abort_wins: got busy=%b adc_en=%b want 0/0", o_busy, o_adc_en);
        end
    endtask

    task automatic test_zero_n_and_reset();
        start_burst(16'd0, 8'd0);
        strobe(20'h00000, 1'b0);
        strobe(20'h00000, 1'b0);
        strobe(20'h00010, 1'b0);
        total++;
        if (o_acc_valid !== 1'b1 || o_acc !== 36'd16 || o_acc_cnt !== 16'd1) begin
            bad++;
            $display("FAIL zero_n: got valid=%b acc=%0d cnt=%0d want 1/16/1", o_acc_valid, o_acc, o_acc_cnt);
        end
        release_result();
        start_burst(16'd5, 8'd0);
        strobe(20'h00000, 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++;
        if ({o_adc_en, o_busy, o_ovl_seen, o_acc_valid, o_done} !== 5'b00000 || o_acc !== 36'd0 || o_acc_cnt !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: got flags=%b acc=%h cnt=%0d want 00000/0/0",
                     {o_adc_en, o_busy, o_ovl_seen, o_acc_valid, o_done}, o_acc, o_acc_cnt);
        end
    endtask

    task automatic test_random();
        logic [19:0]        s;
        logic signed [19:0] ss;
        logic               o;
        longint             exp_sum;
        logic [35:0]        exp_acc;
        logic               exp_ovl;
        int                 n, d, neff, taken, k;
        for (int it = 0; it < 20; it++) begin
            n    = $urandom_range(0, 8);
            d    = $urandom_range(0, 3);
            neff = (n == 0) ? 1 : n;
            start_burst(16'(n), 8'(d));
            for (int j = 0; j < 2; j++) begin
                strobe(20'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            exp_sum = 0;
            exp_ovl = 1'b0;
            taken   = 0;
            k       = 0;
            while (taken < neff) begin
                s  = 20'($urandom);
                ss = s;
                o  = 1'($urandom);
                if (k % (d + 1) == 0) begin
                    exp_sum += longint'(ss);
                    exp_ovl |= o;
                    taken++;
                end
                k++;
                strobe(s, o);
                if (taken < neff) repeat ($urandom_range(0, 2)) tick();
            end
            exp_acc = exp_sum[35:0];
            total++;
            if (o_acc_valid !== 1'b1 || o_acc !== exp_acc || o_acc_cnt !== 16'(neff) || o_ovl_seen !== exp_ovl) begin
                bad++;
                $display("FAIL random_burst %0d: got valid=%b acc=%h cnt=%0d ovl=%b want 1/%h/%0d/%b",
                         it, o_acc_valid, o_acc, o_acc_cnt, o_ovl_seen, exp_acc, neff, exp_ovl);
            end
            repeat ($urandom_range(0, 3)) tick();
            release_result();
            total++;
            if (o_busy !== 1'b0 || o_acc !== exp_acc) begin
                bad++;
                $display("FAIL random_release %0d: got busy=%b acc=%h want 0/%h", it, o_busy, o_acc, exp_acc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_extremes();
        test_backpressure();
        test_abort();
        test_zero_n_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
